// File: rtl/ukf_weight_gen_if.sv
// Handshake and result bus between the UKF weight generator and its requester.
// The requester drives start/alpha/beta/kappa; the generator drives the status and weights.
interface ukf_weight_gen_if #(
  parameter int unsigned DATA_W = 32
) ();
  logic              start;
  logic [DATA_W-1:0] alpha;
  logic [DATA_W-1:0] beta;
  logic [DATA_W-1:0] kappa;
  logic              busy;
  logic              done;
  logic              w_valid;
  logic [DATA_W-1:0] w0m;
  logic [DATA_W-1:0] w0c;
  logic [DATA_W-1:0] wi;
  logic              err;
  logic              ovf;

  modport master (
    output start, alpha, beta, kappa,
    input  busy, done, w_valid, w0m, w0c, wi, err, ovf
  );

  modport slave (
    input  start, alpha, beta, kappa,
    output busy, done, w_valid, w0m, w0c, wi, err, ovf
  );
endinterface

// File: rtl/ukf_weight_gen.sv
// UKF sigma-point weight generator: W0(m), W0(c) and Wi from alpha/beta/kappa,
// using one shared saturating fixed-point multiplier and a bit-serial restoring divider.
module ukf_weight_gen #(
  parameter int unsigned N_STATE   = 6,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned FRAC_BITS = 24,
  parameter int unsigned LANE_LOG2 = 1
) (
  input  logic           i_clk,
  input  logic           i_rst,
  ukf_weight_gen_if.slave bus
);

  localparam int unsigned OPW = DATA_W + 2;
  localparam int unsigned PW  = 2 * OPW;
  localparam int unsigned QW  = 2 * FRAC_BITS;
  localparam int unsigned CW  = $clog2(QW);
  localparam logic [DATA_W-1:0] L_Q   = DATA_W'(N_STATE) << FRAC_BITS;
  localparam logic [DATA_W-1:0] ONE_Q = DATA_W'(1) << FRAC_BITS;
  localparam logic [DATA_W-1:0] SMAX  = {1'b0, {(DATA_W-1){1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE, S_SQ, S_MULC, S_CHK, S_DIV, S_W0, S_FIN
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [DATA_W-1:0] r_alpha, r_beta, r_kappa;
  logic [DATA_W-1:0] r_a, r_c, r_lambda;
  logic [DATA_W-1:0] r_rem;
  logic [QW-1:0]     r_quo;
  logic [CW-1:0]     r_cnt;
  logic              r_busy, r_done, r_w_valid, r_err, r_ovf;
  logic [DATA_W-1:0] r_w0m, r_w0c, r_wi;

  logic signed [OPW-1:0] w_op_a, w_op_b;
  logic signed [PW-1:0]  w_prod, w_prod_sh, w_lk_sum, w_lam_sum, w_w0c_sum;
  logic [DATA_W:0]       w_prod_sat, w_lk_sat, w_lam_sat, w_w0c_sat;
  logic                  w_c_nonpos, w_wi_ovf, w_ge, w_start_acc;
  logic [DATA_W-1:0]     w_wi_sat;
  logic [DATA_W:0]       w_rem_sh, w_dsr;

  // Clamp a wide signed value to DATA_W; MSB of the result flags saturation.
  function automatic logic [DATA_W:0] f_sat(input logic signed [PW-1:0] v);
    if (v[PW-1:DATA_W-1] == {(PW-DATA_W+1){v[PW-1]}})
      return {1'b0, v[DATA_W-1:0]};
    else if (v[PW-1])
      return {1'b1, 1'b1, {(DATA_W-1){1'b0}}};
    else
      return {1'b1, SMAX};
  endfunction

  assign w_start_acc = (r_state == S_IDLE) && bus.start;
  assign w_c_nonpos  = r_c[DATA_W-1] | ~(|r_c);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nx = S_SQ;
      S_SQ:    w_state_nx = S_MULC;
      S_MULC:  w_state_nx = S_CHK;
      S_CHK:   w_state_nx = w_c_nonpos ? S_FIN : S_DIV;
      S_DIV:   if (r_cnt == CW'(QW - 1)) w_state_nx = S_W0;
      S_W0:    w_state_nx = S_FIN;
      S_FIN:   w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Shared multiplier operand select.
  always_comb begin
    w_op_a = '0;
    w_op_b = '0;
    case (r_state)
      S_SQ: begin
        w_op_a = OPW'($signed(r_alpha));
        w_op_b = OPW'($signed(r_alpha));
      end
      S_MULC: begin
        w_op_a = OPW'($signed(r_a));
        w_op_b = OPW'($signed(w_lk_sat[DATA_W-1:0]));
      end
      S_W0: begin
        w_op_a = OPW'($signed(r_lambda));
        w_op_b = OPW'({w_wi_sat, 1'b0});
      end
      default: begin
        w_op_a = '0;
        w_op_b = '0;
      end
    endcase
  end

  assign w_prod     = PW'(w_op_a) * PW'(w_op_b);
  assign w_prod_sh  = w_prod >>> FRAC_BITS;
  assign w_prod_sat = f_sat(w_prod_sh);

  assign w_lk_sum  = PW'($signed(L_Q)) + PW'($signed(r_kappa));
  assign w_lk_sat  = f_sat(w_lk_sum);
  assign w_lam_sum = PW'($signed(r_c)) - PW'($signed(L_Q));
  assign w_lam_sat = f_sat(w_lam_sum);
  assign w_w0c_sum = PW'($signed(w_prod_sat[DATA_W-1:0])) + PW'($signed(ONE_Q))
                   - PW'($signed(r_a)) + PW'($signed(r_beta));
  assign w_w0c_sat = f_sat(w_w0c_sum);

  assign w_wi_ovf = |r_quo[QW-1:DATA_W-1];
  assign w_wi_sat = w_wi_ovf ? SMAX : r_quo[DATA_W-1:0];

  // Dividend is 2^(2F-1) (= 2^(2F)/2): a single leading one, then zeros.
  assign w_rem_sh = {r_rem, (r_cnt == '0)};
  assign w_dsr    = {1'b0, r_c};
  assign w_ge     = (w_rem_sh >= w_dsr);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_alpha   <= '0;
      r_beta    <= '0;
      r_kappa   <= '0;
      r_a       <= '0;
      r_c       <= '0;
      r_lambda  <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_w_valid <= 1'b0;
      r_err     <= 1'b0;
      r_ovf     <= 1'b0;
      r_w0m     <= '0;
      r_w0c     <= '0;
      r_wi      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (w_start_acc) begin
          r_alpha   <= bus.alpha;
          r_beta    <= bus.beta;
          r_kappa   <= bus.kappa;
          r_busy    <= 1'b1;
          r_w_valid <= 1'b0;
          r_err     <= 1'b0;
          r_ovf     <= 1'b0;
        end
        S_SQ: begin
          r_a   <= w_prod_sat[DATA_W-1:0];
          r_ovf <= r_ovf | w_prod_sat[DATA_W];
        end
        S_MULC: begin
          r_c   <= w_prod_sat[DATA_W-1:0];
          r_ovf <= r_ovf | w_prod_sat[DATA_W] | w_lk_sat[DATA_W];
        end
        S_CHK: begin
          r_lambda <= w_lam_sat[DATA_W-1:0];
          r_rem    <= '0;
          r_quo    <= '0;
          r_cnt    <= '0;
          if (w_c_nonpos) begin
            r_err     <= 1'b1;
            r_w0m     <= '0;
            r_w0c     <= '0;
            r_wi      <= '0;
            r_done    <= 1'b1;
            r_w_valid <= 1'b1;
            r_busy    <= 1'b0;
          end else begin
            r_ovf <= r_ovf | w_lam_sat[DATA_W];
          end
        end
        S_DIV: begin
          r_rem <= DATA_W'(w_ge ? (w_rem_sh - w_dsr) : w_rem_sh);
          r_quo <= {r_quo[QW-2:0], w_ge};
          r_cnt <= r_cnt + CW'(1);
        end
        S_W0: begin
          r_wi      <= w_wi_sat;
          r_w0m     <= DATA_W'($signed(w_prod_sat[DATA_W-1:0]) >>> LANE_LOG2);
          r_w0c     <= DATA_W'($signed(w_w0c_sat[DATA_W-1:0]) >>> LANE_LOG2);
          r_ovf     <= r_ovf | w_wi_ovf | w_prod_sat[DATA_W] | w_w0c_sat[DATA_W];
          r_done    <= 1'b1;
          r_w_valid <= 1'b1;
          r_busy    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.w_valid = r_w_valid;
  assign bus.w0m     = r_w0m;
  assign bus.w0c     = r_w0c;
  assign bus.wi      = r_wi;
  assign bus.err     = r_err;
  assign bus.ovf     = r_ovf;

endmodule
